im_multiport: RTL

- Parametrised successor to the per-core instruction memory: one shared program store, NUM_C independent read ports, and a host load port so programs are written at run time instead of being fixed at elaboration.
- Adds per-port request/valid handshake, a post-reset fill sequence, write-first bypass and out-of-range address handling.
- Sits between the per-core fetch stages (PC -> rd_addr) and the host/testbench program loader.

---
 rtl/im_pkg.sv | 17 +
 rtl/im_multiport_if.sv | 41 ++++
 rtl/im_read_port.sv | 79 +++++++
 rtl/im_multiport.sv | 135 +++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// im_pkg: shared constants for the multi-port instruction memory.
// Opcode values, default fill/out-of-range words, init FSM encoding.
package im_pkg;

    localparam logic [15:0] OP_NOP   = 16'd5;
    localparam logic [15:0] OP_LDAC  = 16'd6;
    localparam logic [15:0] OP_ENDOP = 16'd43;

    localparam logic [15:0] FILL_WORD_DEF = OP_NOP;
    localparam logic [15:0] OOB_WORD_DEF  = OP_ENDOP;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } im_state_t;

endpackage

// File: rtl/im_multiport_if.sv
// im_multiport_if: fetch read ports plus host load port of the shared
// instruction memory. IM_PARITY_EN adds parity inject/error signals.
interface im_multiport_if #(
    parameter int NUM_C  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [NUM_C-1:0]        rd_req;
    logic [NUM_C*ADDR_W-1:0] rd_addr;
    logic [NUM_C-1:0]        rd_valid;
    logic [NUM_C*DATA_W-1:0] rd_data;
    logic [NUM_C-1:0]        rd_oob;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    ready;

`ifdef IM_PARITY_EN
    logic                    wr_perr_inj;
    logic [NUM_C-1:0]        rd_perr;

    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data, wr_perr_inj,
        input  rd_valid, rd_data, rd_oob, rd_perr, ready
    );
    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data, wr_perr_inj,
        output rd_valid, rd_data, rd_oob, rd_perr, ready
    );
`else
    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_valid, rd_data, rd_oob, ready
    );
    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_valid, rd_data, rd_oob, ready
    );
`endif

endinterface

// File: rtl/im_read_port.sv
// im_read_port: one fetch port - range check, write-first bypass and
// registered outputs; parity check when IM_PARITY_EN is defined.
module im_read_port
    import im_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int MEM_W  = DATA_W,
    parameter logic [DATA_W-1:0] OOB_WORD = DATA_W'(OOB_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MEM_W-1:0]  mem_word,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              oob
`ifdef IM_PARITY_EN
    ,
    output logic              perr
`endif
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic              accept;
    logic              in_oob;
    logic              hit;
    logic [DATA_W-1:0] data_nxt;

    assign accept = req & ready;
    assign in_oob = {1'b0, addr} >= LIMIT;
    assign hit    = wr_acc && (wr_addr == addr);

    // out-of-range wins over bypass; bypass wins over stored word
    always_comb begin
        data_nxt = mem_word[DATA_W-1:0];
        if (in_oob)
            data_nxt = OOB_WORD;
        else if (hit)
            data_nxt = wr_data;
    end

    // one-cycle valid pulse; data/oob hold between accepted reads
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            oob   <= 1'b0;
        end else begin
            valid <= accept;
            if (accept) begin
                data <= data_nxt;
                oob  <= in_oob;
            end
        end
    end

`ifdef IM_PARITY_EN
    logic bad;

    // stored word plus parity bit must have even weight
    assign bad = ^mem_word;

    // bypass and ENDOP words never come from storage, so never flag
    always_ff @(posedge clk) begin
        if (rst)
            perr <= 1'b0;
        else if (accept)
            perr <= bad & ~in_oob & ~hit;
    end
`endif

endmodule

// File: rtl/im_multiport.sv
// im_multiport: shared program store, NUM_C fetch ports, host load port.
// Define IM_PARITY_EN to store an even-parity bit per word.
module im_multiport
    import im_pkg::*;
#(
    parameter int NUM_C  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF),
    parameter logic [DATA_W-1:0] OOB_WORD  = DATA_W'(OOB_WORD_DEF)
) (
    input logic           clk,
    input logic           rst,
    im_multiport_if.slave bus
);
`ifdef IM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

    im_state_t state;
    im_state_t state_nxt;

    logic [IDX_W-1:0]        cnt;
    logic                    fill_we;
    logic                    ready_q;
    logic                    wr_acc;
    logic [MEM_W-1:0]        fill_entry;
    logic [MEM_W-1:0]        wr_entry;
    logic [MEM_W-1:0]        mem [DEPTH];
    logic [MEM_W-1:0]        mem_rd [NUM_C];
    logic [NUM_C-1:0]        valid_v;
    logic [NUM_C-1:0]        oob_v;
    logic [NUM_C*DATA_W-1:0] data_v;

`ifdef IM_PARITY_EN
    logic [NUM_C-1:0]        perr_v;

    assign fill_entry = {^FILL_WORD, FILL_WORD};
    assign wr_entry   = {(^bus.wr_data) ^ bus.wr_perr_inj, bus.wr_data};
    assign bus.rd_perr = perr_v;
`else
    assign fill_entry = FILL_WORD;
    assign wr_entry   = bus.wr_data;
`endif

    assign wr_acc = ready_q & bus.wr_en & ~rst
                  & ({1'b0, bus.wr_addr} < LIMIT);

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    // next state: sweep to the last word, then run until reset
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT: if (cnt == LAST) state_nxt = S_RUN;
            S_RUN:  state_nxt = S_RUN;
        endcase
    end

    // outputs: fill strobe only while sweeping
    always_comb begin
        fill_we = 1'b0;
        unique case (state)
            S_INIT: fill_we = 1'b1;
            S_RUN:  fill_we = 1'b0;
        endcase
    end

    // fill counter and ready flag, one edge behind S_RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            if (fill_we)
                cnt <= cnt + IDX_W'(1);
            ready_q <= (state == S_RUN);
        end
    end

    // storage: init sweep or an accepted host write
    always_ff @(posedge clk) begin
        if (fill_we)
            mem[cnt] <= fill_entry;
        else if (wr_acc)
            mem[bus.wr_addr[IDX_W-1:0]] <= wr_entry;
    end

    for (genvar i = 0; i < NUM_C; i++) begin : g_port
        assign mem_rd[i] = mem[bus.rd_addr[i*ADDR_W +: IDX_W]];

        im_read_port #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .MEM_W    (MEM_W),
            .OOB_WORD (OOB_WORD)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .ready    (ready_q),
            .req      (bus.rd_req[i]),
            .addr     (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .mem_word (mem_rd[i]),
            .wr_acc   (wr_acc),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .valid    (valid_v[i]),
            .data     (data_v[i*DATA_W +: DATA_W]),
            .oob      (oob_v[i])
`ifdef IM_PARITY_EN
            ,
            .perr     (perr_v[i])
`endif
        );
    end

    assign bus.rd_valid = valid_v;
    assign bus.rd_data  = data_v;
    assign bus.rd_oob   = oob_v;
    assign bus.ready    = ready_q;

endmodule
